// File: rtl/hilo_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } state_e;

  // Counter value of the final CALC iteration for a given operand width.
  function automatic int unsigned iter_last(input int unsigned w);
    return w - 1;
  endfunction

  localparam int unsigned ITER_LAST = iter_last(HILO_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring divide loop on the 2*WIDTH accumulator.
module muldiv_step
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder after the left shift needs one extra bit before the compare.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    fits   = (rem_sh >= {1'b0, operand});
    diff   = rem_sh[WIDTH-1:0] - operand;

    if (is_div) begin
      if (fits) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: owns HI/LO, runs a 32-step mult/div loop, stalls the pipe while busy.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MfReq,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(iter_last(WIDTH));

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q, opnd_q;
  logic               sa_q, sb_q, bzero_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign Busy     = (state_q != IDLE);
  assign Stall    = Busy & (MfReq | Start | MtHi | MtLo);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      // Divide by zero still runs the loop; its result is replaced here.
      if (bzero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = mag(rem, sa_q);
        res_lo = mag(quo, sa_q ^ sb_q);
      end
    end
  end

  // Operand and loop workspace; no reset needed, always loaded before use.
  always_ff @(posedge Clk) begin
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_q    <= op_e'(Op);
          a_q     <= A;
          b_q     <= B;
          sa_q    <= ~Op[0] & A[WIDTH-1];
          sb_q    <= ~Op[0] & B[WIDTH-1];
          bzero_q <= (B == '0);
        end
      end
      PREP: begin
        if (is_div_q) begin
          acc_q  <= {{WIDTH{1'b0}}, mag(a_q, sa_q)};
          opnd_q <= mag(b_q, sb_q);
        end else begin
          acc_q  <= {{WIDTH{1'b0}}, mag(b_q, sb_q)};
          opnd_q <= mag(a_q, sa_q);
        end
      end
      CALC:    acc_q <= acc_next;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      cnt_q   <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!Start) begin
            if (MtHi) HI <= WData;
            if (MtLo) LO <= WData;
          end
        end
        PREP: cnt_q <= '0;
        CALC: cnt_q <= cnt_q + 1'b1;
        FIX: begin
          HI      <= res_hi;
          LO      <= res_lo;
          Done    <= 1'b1;
          DivZero <= is_div_q & bzero_q;
        end
        default: ;
      endcase
    end
  end

endmodule
